serial_frame_rx: RTL and testbench

SERIAL_FRAME_RX -- requirements
Module: serial_frame_rx

---
 rtl/serial_pkg.sv | 29 ++
 rtl/sipo_shift8.sv | 32 +++
 rtl/serial_frame_rx.sv | 118 +++++++++++
 tb/tb_serial_frame_rx.sv | 235 +++++++++++++++++++++++
 4 files changed

// File: rtl/serial_pkg.sv
// ---------------------------------------------------------------------------
// serial_pkg
//   Shared definitions for the serial frame receiver:
//     state_t          - receiver FSM state encoding
//     FRAME_DATA_BITS  - number of payload bits per frame
//     parity_mismatch  - parity check helper used when a frame completes
// ---------------------------------------------------------------------------
package serial_pkg;

  localparam int FRAME_DATA_BITS = 8;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    DATA   = 2'd1,
    PARITY = 2'd2,
    STOP   = 2'd3
  } state_t;

  // XOR of the payload and its parity bit must be 0 for even parity and
  // 1 for odd parity. Returns 1 when the received frame breaks that rule.
  function automatic logic parity_mismatch(
    input logic [FRAME_DATA_BITS-1:0] payload,
    input logic                       parity_bit,
    input logic                       odd
  );
    return (^{payload, parity_bit}) != odd;
  endfunction

endpackage

// File: rtl/sipo_shift8.sv
// ---------------------------------------------------------------------------
// sipo_shift8
//   8-bit LSB-first serial-in / parallel-out register. Each enabled clock
//   shifts the new bit in at the MSB, so after eight shifts the first bit
//   received sits in q[0].
//
//   Ports:
//     clk       in   clock
//     reset     in   asynchronous active-low clear
//     shift_en  in   shift one bit in on this clock
//     sin       in   serial bit
//     q         out  parallel contents
// ---------------------------------------------------------------------------
module sipo_shift8
  import serial_pkg::*;
(
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       shift_en,
  input  logic                       sin,
  output logic [FRAME_DATA_BITS-1:0] q
);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      q <= '0;
    end else if (shift_en) begin
      q <= {sin, q[FRAME_DATA_BITS-1:1]};
    end
  end

endmodule

// File: rtl/serial_frame_rx.sv
// ---------------------------------------------------------------------------
// serial_frame_rx
//   Receives frames of: start(0), 8 data bits LSB first, parity, stop(1).
//   The line is only looked at on clocks where sin_en is high; on all other
//   clocks the receiver state is frozen. Every output is a register, so a
//   completed frame is reported one clock after the stop bit is sampled.
//
//   Parameters:
//     PARITY_ODD   0 = even parity, 1 = odd parity
//
//   Ports:
//     clk          in   clock
//     reset        in   asynchronous active-low reset
//     sin          in   serial line (idle 1)
//     sin_en       in   sample strobe
//     data         out  last successfully framed byte (held between pulses)
//     data_valid   out  one-cycle pulse: new byte on data
//     parity_err   out  one-cycle pulse with data_valid when parity fails
//     framing_err  out  one-cycle pulse when the stop bit sampled 0
//     busy         out  high whenever the FSM is not in IDLE
// ---------------------------------------------------------------------------
module serial_frame_rx
  import serial_pkg::*;
#(
  parameter bit PARITY_ODD = 1'b0
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       sin,
  input  logic       sin_en,
  output logic [7:0] data,
  output logic       data_valid,
  output logic       parity_err,
  output logic       framing_err,
  output logic       busy
);

  localparam logic [2:0] LAST_BIT = 3'(FRAME_DATA_BITS - 1);

  state_t                     state;
  logic [2:0]                 bit_cnt;
  logic                       parity_bit;
  logic [FRAME_DATA_BITS-1:0] shreg;
  logic                       shift_en;

  // The payload register only moves while data bits are being sampled, so
  // it still holds the complete byte when the stop bit arrives.
  assign shift_en = sin_en && (state == DATA);

  sipo_shift8 u_sipo (
    .clk      (clk),
    .reset    (reset),
    .shift_en (shift_en),
    .sin      (sin),
    .q        (shreg)
  );

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state       <= IDLE;
      bit_cnt     <= '0;
      parity_bit  <= 1'b0;
      data        <= '0;
      data_valid  <= 1'b0;
      parity_err  <= 1'b0;
      framing_err <= 1'b0;
      busy        <= 1'b0;
    end else begin
      // Pulses last exactly one clock regardless of sin_en.
      data_valid  <= 1'b0;
      parity_err  <= 1'b0;
      framing_err <= 1'b0;

      if (sin_en) begin
        case (state)
          IDLE: begin
            if (!sin) begin
              state   <= DATA;
              bit_cnt <= '0;
              busy    <= 1'b1;
            end
          end

          DATA: begin
            bit_cnt <= bit_cnt + 3'd1;
            if (bit_cnt == LAST_BIT) begin
              state <= PARITY;
            end
          end

          PARITY: begin
            parity_bit <= sin;
            state      <= STOP;
          end

          STOP: begin
            if (sin) begin
              data       <= shreg;
              data_valid <= 1'b1;
              parity_err <= parity_mismatch(shreg, parity_bit, PARITY_ODD);
            end else begin
              framing_err <= 1'b1;
            end
            // Back in IDLE the very next strobe may already be a start bit.
            state <= IDLE;
            busy  <= 1'b0;
          end

          default: begin
            state <= IDLE;
            busy  <= 1'b0;
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_serial_frame_rx.sv
module tb_serial_frame_rx;

  localparam logic P_ODD = 1'b0;

  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic       sin = 1'b1;
  logic       sin_en = 1'b0;
  logic [7:0] data;
  logic       data_valid;
  logic       parity_err;
  logic       framing_err;
  logic       busy;

  serial_frame_rx #(.PARITY_ODD(P_ODD)) dut (
    .clk         (clk),
    .reset       (reset),
    .sin         (sin),
    .sin_en      (sin_en),
    .data        (data),
    .data_valid  (data_valid),
    .parity_err  (parity_err),
    .framing_err (framing_err),
    .busy        (busy)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fails  = 0;

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] want);
    n_checks++;
    if (got !== want) begin
      n_fails++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, got, want, $time);
    end
  endtask

  // Reference model: collects the sampled bits of a frame as a plain bit
  // vector (index 0 = start bit ... 10 = stop bit) and derives the results
  // once all eleven bits are in.
  bit         m_in_frame = 0;
  int         m_n = 0;
  logic [10:0] m_frame = '0;
  logic [7:0] e_data = '0;
  logic       e_dv = 0, e_pe = 0, e_fe = 0, e_busy = 0;
  int         strobes = 0;

  typedef struct {
    logic [7:0] d;
    logic       pe;
    logic       fe;
    int         at;
  } ev_t;
  ev_t log_q[$];

  initial begin
    logic s, e;
    forever begin
      @(posedge clk);
      s = sin;
      e = sin_en;
      #1;
      e_dv = 0; e_pe = 0; e_fe = 0;
      if (!reset) begin
        m_in_frame = 0; m_n = 0; m_frame = '0; e_data = '0;
      end else if (e) begin
        strobes++;
        if (!m_in_frame) begin
          if (!s) begin
            m_in_frame = 1; m_n = 1; m_frame = '0;
          end
        end else begin
          m_frame[m_n] = s;
          m_n++;
          if (m_n == 11) begin
            m_in_frame = 0;
            if (s) begin
              e_data = m_frame[8:1];
              e_dv   = 1;
              e_pe   = ((^m_frame[9:1]) != P_ODD);
            end else begin
              e_fe = 1;
            end
          end
        end
      end
      e_busy = m_in_frame;
      check("data",        {24'd0, data}, {24'd0, e_data});
      check("data_valid",  {31'd0, data_valid},  {31'd0, e_dv});
      check("parity_err",  {31'd0, parity_err},  {31'd0, e_pe});
      check("framing_err", {31'd0, framing_err}, {31'd0, e_fe});
      check("busy",        {31'd0, busy},        {31'd0, e_busy});
      if (data_valid || framing_err)
        log_q.push_back('{d: data, pe: parity_err, fe: framing_err, at: strobes});
    end
  end

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  task automatic strobe(input logic b, input int gap);
    repeat (gap) begin
      sin_en = 1'b0;
      sin = 1'($urandom_range(0, 1));
      tick();
    end
    sin_en = 1'b1;
    sin = b;
    tick();
    sin_en = 1'b0;
    sin = 1'b1;
  endtask

  task automatic send_frame(input logic [7:0] d, input logic p, input logic stp, input int gap);
    strobe(1'b0, gap);
    for (int i = 0; i < 8; i++) strobe(d[i], gap);
    strobe(p, gap);
    strobe(stp, gap);
  endtask

  task automatic idle(input int n);
    repeat (n) begin
      sin_en = 1'b1;
      sin = 1'b1;
      tick();
    end
    sin_en = 1'b0;
  endtask

  initial begin
    ev_t ev0, ev1;
    logic [7:0] rd;
    logic rp, rs;
    // reset state
    repeat (3) tick();
    check("rst_data", {24'd0, data}, 32'd0);
    check("rst_busy", {31'd0, busy}, 32'd0);
    reset = 1'b1;
    idle(2);

    // Scenario 1: 0xA5, correct even parity (0)
    log_q.delete();
    send_frame(8'hA5, 1'b0, 1'b1, 0);
    idle(2);
    ev0 = log_q[0];
    check("s1_count", log_q.size(), 1);
    check("s1_data", {24'd0, ev0.d}, 32'hA5);
    check("s1_pe", {31'd0, ev0.pe}, 0);
    check("s1_fe", {31'd0, ev0.fe}, 0);

    // Scenario 2: 0xA5 with wrong parity bit
    log_q.delete();
    send_frame(8'hA5, 1'b1, 1'b1, 0);
    idle(2);
    ev0 = log_q[0];
    check("s2_count", log_q.size(), 1);
    check("s2_data", {24'd0, ev0.d}, 32'hA5);
    check("s2_pe", {31'd0, ev0.pe}, 1);

    // Scenario 4: sparse strobes, 0x3C, busy window
    log_q.delete();
    strobe(1'b0, 2);
    check("s4_busy_start", {31'd0, busy}, 1);
    for (int i = 0; i < 8; i++) strobe(rd_bit(8'h3C, i), 2);
    strobe(1'b0, 2);
    check("s4_busy_parity", {31'd0, busy}, 1);
    strobe(1'b1, 2);
    check("s4_busy_end", {31'd0, busy}, 0);
    idle(2);
    ev0 = log_q[0];
    check("s4_count", log_q.size(), 1);
    check("s4_data", {24'd0, ev0.d}, 32'h3C);

    // Scenario 3: 0xA5 with stop bit 0, data keeps 0x3C
    log_q.delete();
    send_frame(8'hA5, 1'b0, 1'b0, 0);
    idle(2);
    ev0 = log_q[0];
    check("s3_count", log_q.size(), 1);
    check("s3_fe", {31'd0, ev0.fe}, 1);
    check("s3_data_kept", {24'd0, data}, 32'h3C);

    // Scenario 5: reset mid-frame, then 0x3C
    log_q.delete();
    strobe(1'b0, 0);
    for (int i = 0; i < 4; i++) strobe(1'b1, 0);
    reset = 1'b0;
    repeat (3) tick();
    check("s5_rst_busy", {31'd0, busy}, 0);
    check("s5_rst_data", {24'd0, data}, 0);
    reset = 1'b1;
    idle(1);
    send_frame(8'h3C, 1'b0, 1'b1, 0);
    idle(2);
    ev0 = log_q[0];
    check("s5_count", log_q.size(), 1);
    check("s5_data", {24'd0, ev0.d}, 32'h3C);

    // Scenario 6: back-to-back 0x01 / 0xFF
    log_q.delete();
    send_frame(8'h01, 1'b1, 1'b1, 0);
    send_frame(8'hFF, 1'b0, 1'b1, 0);
    idle(2);
    ev0 = log_q[0];
    ev1 = log_q[1];
    check("s6_count", log_q.size(), 2);
    check("s6_data0", {24'd0, ev0.d}, 32'h01);
    check("s6_data1", {24'd0, ev1.d}, 32'hFF);
    check("s6_spacing", ev1.at - ev0.at, 11);
    check("s6_err", {30'd0, ev0.pe | ev1.pe, ev0.fe | ev1.fe}, 0);

    // Randomized frames against the model
    for (int k = 0; k < 40; k++) begin
      rd = 8'($urandom);
      rp = ($urandom_range(0, 3) == 0) ? ~^rd : ^rd;
      rs = ($urandom_range(0, 4) != 0);
      send_frame(rd, rp, rs, $urandom_range(0, 2));
      idle($urandom_range(0, 2));
      $display("frame %0d: byte %02h parity %0b stop %0b -> data %02h", k, rd, rp, rs, data);
    end
    idle(3);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
    $finish;
  end

  function automatic logic rd_bit(input logic [7:0] v, input int i);
    return v[i];
  endfunction

endmodule
